inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Upstream feeder of the instruction BRAM used by the CPU core.
- Consumes the byte stream pulled from the UART RX FIFO during the load phase.
- Parses a 4-byte length header, assembles big-endian 32-bit instruction words and writes each word to BRAM port A.
- Reports completion or error so the core can leave the load phase without a manual button press.

Parameters:
- DEPTH_WORDS, 32768, capacity of instruction BRAM in words; larger header length is an error.
- BASE_ADDR, 32'h0, byte address of the first word written.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- byte_data  in  8  received byte
- byte_valid  in  1  one-cycle strobe, byte_data valid
- clear  in  1  one-cycle strobe, abort and re-arm to HDR
- inst_addra  out  32  BRAM port A byte address
- inst_dina  out  32  BRAM port A write data
- inst_wea  out  4  BRAM port A byte write enable
- busy  out  1  high in HDR (after first byte) and DATA
- done  out  1  level, load completed successfully
- error  out  1  level, load aborted
- word_count  out  32  words written so far

Behaviour:
- Reset rstn, synchronous, active-low; clock clk.
- Reset values: inst_addra=BASE_ADDR, inst_dina=0, inst_wea=0, busy=0, done=0, error=0, word_count=0; state=HDR, byte index=0.
- States: HDR, DATA, DONE, ERR.
- Byte order is big-endian throughout: byte 0 of a group goes to [31:24], byte 3 to [7:0]. A 2-bit byte index counts bytes within the current group and wraps 3 -> 0.
- HDR: collect 4 bytes into len.
  - On the 4th byte: len==0 -> DONE; len>DEPTH_WORDS -> ERR; else -> DATA.
- DATA: shift bytes into the word register.
  - On the 4th byte, the next cycle drives inst_wea=4'b1111, inst_dina=word, inst_addra=BASE_ADDR+(word_count<<2), and word_count increments in the same cycle.
  - inst_wea is high for exactly one cycle per word and is 0 otherwise. Write latency is 1 cycle from the 4th byte_valid.
  - When word_count reaches len (the cycle of the last write) -> DONE.
- DONE/ERR: byte_valid is ignored; outputs hold; only clear or reset leaves.
- clear, from any state: state=HDR, byte index=0, word_count=0, done=0, error=0, inst_wea=0.
  - clear and byte_valid in the same cycle: clear wins, the byte is dropped.
  - clear in the same cycle as a pending write: the write is suppressed.
- Back-to-back byte_valid on consecutive cycles must be accepted without loss (max rate 1 byte/cycle).
- Arithmetic: word_count and len are 32-bit unsigned. Address wraps mod 2^32 (unreachable when DEPTH_WORDS is respected).
- Reset mid-load: identical to reset at power-up; partially written BRAM contents are left as-is.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined: after the last data word, a CHK state collects a 4-byte big-endian trailer.
  - Trailer == 32-bit wrapping sum of all data words -> DONE, else -> ERR.
  - len==0 also expects the trailer, which must be 0.
  - busy stays high in CHK.
- Not defined: no CHK state, no trailer, DONE directly after the last word.

Decomposition:
- Package inst_loader_pkg:
  - enum loader_state_type {HDR_ST, DATA_ST, CHK_ST, DONE_ST, ERR_ST}
  - localparam HDR_BYTES=4
  - localparam WORD_BYTES=4
- One sub-module, byte_packer: 2-bit index plus 32-bit shift register, outputs word and a word_valid pulse, with a clear input. It is shared by the header, data and checksum phases.

Test Plan:
- Bytes 00 00 00 02, DE AD BE EF, 01 23 45 67 -> writes 32'hDEADBEEF @0x0 and 32'h01234567 @0x4, each with wea=F for 1 cycle; done=1; word_count=2.
- Header 00 00 00 00 -> done=1 the cycle after the 4th byte; no write; extra bytes are ignored.
- Header 00 00 80 01 with DEPTH_WORDS=32768 -> error=1, no writes.
- 3 bytes of a data word, then clear together with a 4th byte_valid -> no write, state HDR, word_count=0; a subsequent valid 1-word load succeeds.
- Continuous byte_valid for 12 bytes (len=2) -> both words written correctly, no dropped bytes.
- With INST_LOADER_CHECKSUM_EN: len=2, words 1 and 2, trailer 00 00 00 03 -> done=1; trailer 00 00 00 04 -> error=1.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Holds the FSM state enum and the byte-group sizes used by the packer.
package inst_loader_pkg;

    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        HDR_ST,
        DATA_ST,
        CHK_ST,
        DONE_ST,
        ERR_ST
    } loader_state_type;

endpackage

// File: rtl/inst_loader_if.sv
// Loader bus: UART byte stream in, BRAM port A write and status out.
// master : the loader side (consumes bytes, drives BRAM port A and status)
// slave  : the feeder/observer side (drives bytes and clear)
interface inst_loader_if;

    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        clear;
    logic [31:0] inst_addra;
    logic [31:0] inst_dina;
    logic [3:0]  inst_wea;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] word_count;

    modport master (
        input  byte_data, byte_valid, clear,
        output inst_addra, inst_dina, inst_wea, busy, done, error, word_count
    );

    modport slave (
        output byte_data, byte_valid, clear,
        input  inst_addra, inst_dina, inst_wea, busy, done, error, word_count
    );

endinterface

// File: rtl/inst_loader_byte_packer.sv
// Big-endian byte-to-word packer shared by the header, data and trailer phases.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   clear          drops any partial group and re-arms the byte index
//   byte_valid     byte_data is accepted this cycle
//   byte_data      incoming byte
//   word_c         assembled word, valid together with word_valid_c
//   word_valid_c   high in the cycle the last byte of a group is accepted
// The completed word is presented combinationally so the caller can register
// the write in the same edge that accepts the last byte (1-cycle latency).
module inst_loader_byte_packer
    import inst_loader_pkg::*;
#(
    parameter int unsigned GROUP_BYTES = WORD_BYTES
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_c,
    output logic        word_valid_c
);

    localparam int unsigned IDX_W  = $clog2(GROUP_BYTES);
    localparam int unsigned HOLD_W = 8 * (GROUP_BYTES - 1);

    logic [IDX_W-1:0]  idx;
    logic [HOLD_W-1:0] shift;

    // Earlier bytes of the group sit above the byte arriving now.
    assign word_c       = {shift, byte_data};
    assign word_valid_c = byte_valid && !clear && (idx == IDX_W'(GROUP_BYTES - 1));

    // Byte index wraps at the group size; shift holds the earlier bytes.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            idx   <= '0;
            shift <= '0;
        end else if (byte_valid) begin
            idx   <= idx + IDX_W'(1);
            shift <= {shift[HOLD_W-9:0], byte_data};
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Instruction BRAM loader: parses a 4-byte big-endian length header, then
// packs big-endian data words and writes them to BRAM port A.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   bus         inst_loader_if.master: byte_data/byte_valid/clear in;
//               inst_addra/inst_dina/inst_wea, busy, done, error, word_count out
// Parameters: DEPTH_WORDS (max accepted length), BASE_ADDR (first byte address).
// Optional: define INST_LOADER_CHECKSUM_EN to require a 4-byte trailer equal to
// the wrapping 32-bit sum of the data words before reporting done.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32768,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic          clk,
    input  logic          rstn,
    inst_loader_if.master bus
);

`ifdef INST_LOADER_CHECKSUM_EN
    localparam loader_state_type END_ST = CHK_ST;
`else
    localparam loader_state_type END_ST = DONE_ST;
`endif

    loader_state_type state, state_d;

    logic [31:0] len, len_d;
    logic [31:0] word_count, word_count_d;
    logic [31:0] addra, addra_d;
    logic [31:0] dina, dina_d;
    logic [3:0]  wea, wea_d;
    logic        busy, busy_d;
    logic        done, done_d;
    logic        error, error_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [31:0] sum, sum_d;
`endif

    logic        byte_take_c;
    logic [31:0] word_c;
    logic        word_valid_c;

    // Bytes are only consumed while a load is in progress; DONE/ERR ignore them.
    assign byte_take_c = bus.byte_valid &&
                         ((state == HDR_ST) || (state == DATA_ST) || (state == CHK_ST));

    inst_loader_byte_packer #(
        .GROUP_BYTES (HDR_BYTES)
    ) u_packer (
        .clk          (clk),
        .rstn         (rstn),
        .clear        (bus.clear),
        .byte_valid   (byte_take_c),
        .byte_data    (bus.byte_data),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= HDR_ST;
            len        <= '0;
            word_count <= '0;
            addra      <= BASE_ADDR;
            dina       <= '0;
            wea        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            state      <= state_d;
            len        <= len_d;
            word_count <= word_count_d;
            addra      <= addra_d;
            dina       <= dina_d;
            wea        <= wea_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
`ifdef INST_LOADER_CHECKSUM_EN
            sum        <= sum_d;
`endif
        end
    end

    // Next state: every transition happens on a completed 4-byte group.
    always_comb begin
        state_d = state;
        if (bus.clear) begin
            state_d = HDR_ST;
        end else if (word_valid_c) begin
            unique case (state)
                HDR_ST: begin
                    if (word_c == 32'd0) begin
                        state_d = END_ST;
                    end else if (word_c > 32'(DEPTH_WORDS)) begin
                        state_d = ERR_ST;
                    end else begin
                        state_d = DATA_ST;
                    end
                end
                DATA_ST: begin
                    // Leave on the cycle of the last write.
                    if ((word_count + 32'd1) == len) begin
                        state_d = END_ST;
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                CHK_ST: begin
                    state_d = (word_c == sum) ? DONE_ST : ERR_ST;
                end
`endif
                default: ;
            endcase
        end
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        len_d        = len;
        word_count_d = word_count;
        addra_d      = addra;
        dina_d       = dina;
        wea_d        = 4'b0000;
        busy_d       = busy;
        done_d       = done;
        error_d      = error;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d        = sum;
`endif
        if (bus.clear) begin
            // Clear wins over a same-cycle byte and suppresses any write.
            word_count_d = '0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            error_d      = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_d        = '0;
`endif
        end else begin
            if (byte_take_c && (state == HDR_ST)) begin
                busy_d = 1'b1;
            end
            if (word_valid_c && (state == HDR_ST)) begin
                len_d = word_c;
`ifdef INST_LOADER_CHECKSUM_EN
                sum_d = '0;
`endif
            end
            if (word_valid_c && (state == DATA_ST)) begin
                wea_d        = 4'b1111;
                dina_d       = word_c;
                addra_d      = BASE_ADDR + (word_count << 2);
                word_count_d = word_count + 32'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                sum_d        = sum + word_c;
`endif
            end
            unique case (state_d)
                DATA_ST, CHK_ST: busy_d = 1'b1;
                DONE_ST: begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                ERR_ST: begin
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.inst_addra = addra;
    assign bus.inst_dina  = dina;
    assign bus.inst_wea   = wea;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.error      = error;
    assign bus.word_count = word_count;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader (default parameters).
module tb_inst_loader;

    logic clk;
    logic rstn;

    inst_loader_if bus ();

    inst_loader #(
        .DEPTH_WORDS (32768),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Write log captured away from the clock edge.
    int          wr_n = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    logic [3:0]  wr_we   [16];

    always @(negedge clk) begin
        if (bus.inst_wea !== 4'h0) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] = bus.inst_addra;
                wr_data[wr_n] = bus.inst_dina;
                wr_we[wr_n]   = bus.inst_wea;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send(t[31:24]);
            t = t << 8;
            if (gaps) tick();
        end
    endtask

    task automatic send_trailer(input logic [31:0] s);
`ifdef INST_LOADER_CHECKSUM_EN
        send_word(s, 1'b0);
`else
        if (s === 32'hx) tick();
`endif
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    int base_n;

    initial begin
        rstn           = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_valid = 1'b0;
        bus.clear      = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Reset state
        check("rst_addra", bus.inst_addra, 32'h0);
        check("rst_dina", bus.inst_dina, 32'h0);
        check("rst_wea", 32'(bus.inst_wea), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_error", 32'(bus.error), 32'h0);
        check("rst_wc", bus.word_count, 32'h0);

        // Two-word load with idle gaps between bytes
        send(8'h00);
        check("t1_busy_hdr", 32'(bus.busy), 32'h1);
        tick();
        send(8'h00); tick();
        send(8'h00); tick();
        send(8'h02); tick();
        check("t1_busy_data", 32'(bus.busy), 32'h1);
        send(8'hDE); tick();
        send(8'hAD); tick();
        send(8'hBE); tick();
        send(8'hEF);
        check("t1_wea_lat", 32'(bus.inst_wea), 32'hF);
        check("t1_dina0", bus.inst_dina, 32'hDEADBEEF);
        check("t1_wc1", bus.word_count, 32'h1);
        tick();
        check("t1_wea_pulse", 32'(bus.inst_wea), 32'h0);
        send_word(32'h01234567, 1'b1);
        send_trailer(32'hDFD10456);
        tick();
        check("t1_done", 32'(bus.done), 32'h1);
        check("t1_error", 32'(bus.error), 32'h0);
        check("t1_busy_end", 32'(bus.busy), 32'h0);
        check("t1_wc", bus.word_count, 32'h2);
        check("t1_nwr", 32'(wr_n), 32'h2);
        check("t1_addr0", wr_addr[0], 32'h0);
        check("t1_data0", wr_data[0], 32'hDEADBEEF);
        check("t1_we0", 32'(wr_we[0]), 32'hF);
        check("t1_addr1", wr_addr[1], 32'h4);
        check("t1_data1", wr_data[1], 32'h01234567);
        check("t1_we1", 32'(wr_we[1]), 32'hF);

        // Empty load: done right after the header, later bytes ignored
        do_clear();
        check("t2_clr_done", 32'(bus.done), 32'h0);
        check("t2_clr_wc", bus.word_count, 32'h0);
        base_n = wr_n;
        send_word(32'h00000000, 1'b0);
        send_trailer(32'h00000000);
        check("t2_done", 32'(bus.done), 32'h1);
        send_word(32'h12345678, 1'b0);
        send_word(32'h9ABCDEF0, 1'b0);
        tick();
        check("t2_done_hold", 32'(bus.done), 32'h1);
        check("t2_wc", bus.word_count, 32'h0);
        check("t2_nwr", 32'(wr_n - base_n), 32'h0);

        // Oversize header: error, no writes
        do_clear();
        base_n = wr_n;
        send_word(32'h00008001, 1'b0);
        check("t3_error", 32'(bus.error), 32'h1);
        check("t3_done", 32'(bus.done), 32'h0);
        check("t3_busy", 32'(bus.busy), 32'h0);
        send_word(32'h11223344, 1'b0);
        tick();
        check("t3_nwr", 32'(wr_n - base_n), 32'h0);
        check("t3_err_hold", 32'(bus.error), 32'h1);

        // Clear colliding with the 4th byte of a word drops the write
        do_clear();
        check("t4_clr_error", 32'(bus.error), 32'h0);
        base_n = wr_n;
        send_word(32'h00000002, 1'b0);
        send_word(32'h11111111, 1'b0);
        check("t4_wc1", bus.word_count, 32'h1);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        bus.byte_data  = 8'h55;
        bus.byte_valid = 1'b1;
        bus.clear      = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
        bus.clear      = 1'b0;
        check("t4_wea", 32'(bus.inst_wea), 32'h0);
        check("t4_wc0", bus.word_count, 32'h0);
        check("t4_busy", 32'(bus.busy), 32'h0);
        tick();
        check("t4_nwr", 32'(wr_n - base_n), 32'h1);
        send_word(32'h00000001, 1'b0);
        send_word(32'hAABBCCDD, 1'b0);
        send_trailer(32'hAABBCCDD);
        tick();
        check("t4_done", 32'(bus.done), 32'h1);
        check("t4_wc", bus.word_count, 32'h1);
        check("t4_nwr2", 32'(wr_n - base_n), 32'h2);
        check("t4_addr", wr_addr[base_n + 1], 32'h0);
        check("t4_data", wr_data[base_n + 1], 32'hAABBCCDD);

        // Twelve back-to-back bytes
        do_clear();
        base_n = wr_n;
        send_word(32'h00000002, 1'b0);
        send_word(32'h11223344, 1'b0);
        send_word(32'h55667788, 1'b0);
        send_trailer(32'h6688AACC);
        tick();
        check("t5_done", 32'(bus.done), 32'h1);
        check("t5_wc", bus.word_count, 32'h2);
        check("t5_nwr", 32'(wr_n - base_n), 32'h2);
        check("t5_addr0", wr_addr[base_n], 32'h0);
        check("t5_data0", wr_data[base_n], 32'h11223344);
        check("t5_addr1", wr_addr[base_n + 1], 32'h4);
        check("t5_data1", wr_data[base_n + 1], 32'h55667788);

`ifdef INST_LOADER_CHECKSUM_EN
        // Trailer checks
        do_clear();
        send_word(32'h00000002, 1'b0);
        send_word(32'h00000001, 1'b0);
        send_word(32'h00000002, 1'b0);
        check("t6_busy_chk", 32'(bus.busy), 32'h1);
        send_word(32'h00000003, 1'b0);
        check("t6_done", 32'(bus.done), 32'h1);
        do_clear();
        send_word(32'h00000002, 1'b0);
        send_word(32'h00000001, 1'b0);
        send_word(32'h00000002, 1'b0);
        send_word(32'h00000004, 1'b0);
        check("t6_error", 32'(bus.error), 32'h1);
        check("t6_nodone", 32'(bus.done), 32'h0);
`endif

        // Reset mid-load returns everything to power-up values
        do_clear();
        send_word(32'h00000002, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("t7_wc", bus.word_count, 32'h0);
        check("t7_busy", 32'(bus.busy), 32'h0);
        check("t7_addra", bus.inst_addra, 32'h0);
        check("t7_dina", bus.inst_dina, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
